// File: rtl/output_vc_state_pkg.sv
// Shared constants and types for the output-VC bookkeeping slice.
package output_vc_state_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;

    // Smallest n with 2**n >= value (returns 0 for value <= 1).
    function automatic int unsigned clog_b2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // One extra bit so the counter can hold DEPTH itself.
    localparam int unsigned DEFAULT_CREDIT_WIDTH = clog_b2(DEFAULT_DEPTH) + 1;

    // Net per-cycle change applied to one credit counter.
    typedef enum logic [1:0] {
        DELTA_HOLD = 2'd0,
        DELTA_UP   = 2'd1,
        DELTA_DOWN = 2'd2
    } credit_delta_e;

endpackage

// File: rtl/output_vc_state_if.sv
// Allocator/link-side signals of one router output's OVC bookkeeping.
interface output_vc_state_if #(
    parameter int unsigned VC_WIDTH = 1,
    parameter int unsigned NOVCS    = 2
);
    logic                alloc_enable;
    logic [VC_WIDTH-1:0] alloc_vc;
    logic                send_valid;
    logic [VC_WIDTH-1:0] send_vc;
    logic                send_tail;
    logic                credit_valid;
    logic [VC_WIDTH-1:0] credit_vc;
    logic [NOVCS-1:0]    ovc_available;
    logic [NOVCS-1:0]    ovc_ready;
    logic                error;

    modport master (
        output alloc_enable, alloc_vc, send_valid, send_vc, send_tail,
               credit_valid, credit_vc,
        input  ovc_available, ovc_ready, error
    );

    modport slave (
        input  alloc_enable, alloc_vc, send_valid, send_vc, send_tail,
               credit_valid, credit_vc,
        output ovc_available, ovc_ready, error
    );
endinterface

// File: rtl/output_vc_state_ovc_credit_counter.sv
// Saturating credit counter for one OVC; resets to DEPTH (empty downstream buffer).
module ovc_credit_counter
    import output_vc_state_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned CREDIT_WIDTH = DEFAULT_CREDIT_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    dec,
    output logic [CREDIT_WIDTH-1:0] count,
    output logic                    overflow,
    output logic                    underflow
);

    credit_delta_e delta;

    // Net delta for this cycle; an out-of-range step is dropped and flagged.
    always_comb begin
        delta     = DELTA_HOLD;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (inc && !dec) begin
            if (count == CREDIT_WIDTH'(DEPTH)) overflow = 1'b1;
            else                               delta    = DELTA_UP;
        end else if (dec && !inc) begin
            if (count == '0) underflow = 1'b1;
            else             delta     = DELTA_DOWN;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= CREDIT_WIDTH'(DEPTH);
        end else begin
            case (delta)
                DELTA_UP:   count <= count + CREDIT_WIDTH'(1);
                DELTA_DOWN: count <= count - CREDIT_WIDTH'(1);
                default:    count <= count;
            endcase
        end
    end

endmodule

// File: rtl/output_vc_state.sv
// Ownership and credit state for the output VCs of one router port.
module output_vc_state
    import output_vc_state_pkg::*;
#(
    parameter int unsigned VC_WIDTH     = 1,
    parameter int unsigned NOVCS        = 2,
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned CREDIT_WIDTH = DEFAULT_CREDIT_WIDTH
) (
    input logic               clock,
    input logic               reset,
    output_vc_state_if.slave  bus
);

    logic [NOVCS-1:0]        busy;
    logic [NOVCS-1:0]        alloc_hit;
    logic [NOVCS-1:0]        send_hit;
    logic [NOVCS-1:0]        credit_hit;
    logic [NOVCS-1:0]        tail_release;
    logic [NOVCS-1:0]        double_alloc;
    logic [NOVCS-1:0]        overflow;
    logic [NOVCS-1:0]        underflow;
    logic                    bad_index;
    logic                    error_reg;
    logic [CREDIT_WIDTH-1:0] credit [NOVCS];

    // One-hot event decode; an index with no matching OVC decodes to zero and is flagged.
    always_comb begin
        alloc_hit  = '0;
        send_hit   = '0;
        credit_hit = '0;
        for (int unsigned v = 0; v < NOVCS; v++) begin
            alloc_hit[v]  = bus.alloc_enable && (bus.alloc_vc  == VC_WIDTH'(v));
            send_hit[v]   = bus.send_valid   && (bus.send_vc   == VC_WIDTH'(v));
            credit_hit[v] = bus.credit_valid && (bus.credit_vc == VC_WIDTH'(v));
        end
        tail_release = send_hit & {NOVCS{bus.send_tail}};
        double_alloc = alloc_hit & busy & ~tail_release;
        bad_index    = (bus.alloc_enable && (alloc_hit  == '0)) ||
                       (bus.send_valid   && (send_hit   == '0)) ||
                       (bus.credit_valid && (credit_hit == '0));
    end

    // Ownership: a same-cycle alloc wins over a tail release.
    always_ff @(posedge clock) begin
        if (reset) busy <= '0;
        else       busy <= alloc_hit | (busy & ~tail_release);
    end

    for (genvar g = 0; g < NOVCS; g++) begin : gen_credit
        ovc_credit_counter #(
            .DEPTH        (DEPTH),
            .CREDIT_WIDTH (CREDIT_WIDTH)
        ) u_counter (
            .clock     (clock),
            .reset     (reset),
            .inc       (credit_hit[g]),
            .dec       (send_hit[g]),
            .count     (credit[g]),
            .overflow  (overflow[g]),
            .underflow (underflow[g])
        );
    end

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) error_reg <= 1'b0;
        else       error_reg <= error_reg | (|double_alloc) | (|overflow) |
                                (|underflow) | bad_index;
    end

    // Allocator masks derived from registered state only.
    always_comb begin
        bus.ovc_available = ~busy;
        bus.ovc_ready     = '0;
        for (int unsigned v = 0; v < NOVCS; v++) begin
            bus.ovc_ready[v] = (credit[v] != '0);
        end
        bus.error = error_reg;
    end

endmodule

// File: tb/tb_output_vc_state.sv
// Directed bench for output_vc_state with hand-computed expected masks.
module tb_output_vc_state;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    output_vc_state_if #(.VC_WIDTH(1), .NOVCS(2)) bus ();

    output_vc_state #(
        .VC_WIDTH     (1),
        .NOVCS        (2),
        .DEPTH        (4),
        .CREDIT_WIDTH (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.alloc_enable = 1'b0;
        bus.alloc_vc     = 1'b0;
        bus.send_valid   = 1'b0;
        bus.send_vc      = 1'b0;
        bus.send_tail    = 1'b0;
        bus.credit_valid = 1'b0;
        bus.credit_vc    = 1'b0;
    endtask

    // Apply the currently driven inputs for one clock edge, then clear them.
    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic alloc(input logic vc);
        bus.alloc_enable = 1'b1; bus.alloc_vc = vc;
    endtask

    task automatic send(input logic vc, input logic tail);
        bus.send_valid = 1'b1; bus.send_vc = vc; bus.send_tail = tail;
    endtask

    task automatic credit(input logic vc);
        bus.credit_valid = 1'b1; bus.credit_vc = vc;
    endtask

    task automatic check_all(input string tag, input logic [1:0] avail,
                             input logic [1:0] ready, input logic err);
        check({tag, ".avail"}, 32'(bus.ovc_available), 32'(avail));
        check({tag, ".ready"}, 32'(bus.ovc_ready), 32'(ready));
        check({tag, ".error"}, 32'(bus.error), 32'(err));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();
        @(negedge clock);

        // Reset state
        do_reset();
        check_all("reset", 2'b11, 2'b11, 1'b0);

        // Allocate VC1, four flits, last is tail
        alloc(1'b1); step();
        check_all("alloc1", 2'b01, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) begin send(1'b1, 1'b0); step(); end
        check_all("send1x3", 2'b01, 2'b11, 1'b0);
        send(1'b1, 1'b1); step();
        check_all("tail1", 2'b11, 2'b01, 1'b0);
        credit(1'b1); step();
        check("credit1_first.ready", 32'(bus.ovc_ready), 32'(2'b11));
        for (int i = 0; i < 3; i++) begin credit(1'b1); step(); end
        check_all("credit1x4", 2'b11, 2'b11, 1'b0);

        // Simultaneous send+credit on VC0 with credit 2
        send(1'b0, 1'b0); step();
        send(1'b0, 1'b0); step();
        send(1'b0, 1'b0); credit(1'b0); step();
        check_all("send_credit0", 2'b11, 2'b11, 1'b0);
        // Tail and alloc on VC0 together: stays owned, credit 2 -> 1
        alloc(1'b0); step();
        check("alloc0.avail", 32'(bus.ovc_available), 32'(2'b10));
        send(1'b0, 1'b1); alloc(1'b0); step();
        check_all("tail_alloc0", 2'b10, 2'b11, 1'b0);
        send(1'b0, 1'b0); step();
        check_all("drain0", 2'b10, 2'b10, 1'b0);

        // Underflow on VC0
        send(1'b0, 1'b0); step();
        check_all("underflow0", 2'b10, 2'b10, 1'b1);
        step();
        check("underflow0_sticky.error", 32'(bus.error), 32'd1);
        credit(1'b0); step();
        check("after_underflow_credit.ready", 32'(bus.ovc_ready), 32'(2'b11));
        send(1'b0, 1'b0); step();
        check("after_underflow_send.ready", 32'(bus.ovc_ready), 32'(2'b10));

        // Overflow on VC1 at DEPTH: saturates at 4
        do_reset();
        check_all("reset2", 2'b11, 2'b11, 1'b0);
        credit(1'b1); step();
        check_all("overflow1", 2'b11, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) begin send(1'b1, 1'b0); step(); end
        check("overflow1_send3.ready", 32'(bus.ovc_ready), 32'(2'b11));
        send(1'b1, 1'b0); step();
        check("overflow1_send4.ready", 32'(bus.ovc_ready), 32'(2'b01));

        // Double allocation of VC0
        do_reset();
        alloc(1'b0); step();
        check_all("dalloc_first", 2'b10, 2'b11, 1'b0);
        alloc(1'b0); step();
        check_all("dalloc_second", 2'b10, 2'b11, 1'b1);

        // Reset mid-packet, with inputs active during reset
        do_reset();
        alloc(1'b1); step();
        send(1'b1, 1'b0); step();
        send(1'b1, 1'b0); step();
        check_all("midpkt", 2'b01, 2'b11, 1'b0);
        reset = 1'b1;
        alloc(1'b0); send(1'b1, 1'b0); credit(1'b0);
        step();
        reset = 1'b0;
        check_all("midpkt_reset", 2'b11, 2'b11, 1'b0);
        // Four sends on VC1 must be needed to exhaust it again
        for (int i = 0; i < 3; i++) begin send(1'b1, 1'b0); step(); end
        check("post_reset_send3.ready", 32'(bus.ovc_ready), 32'(2'b11));
        send(1'b1, 1'b0); step();
        check_all("post_reset_send4", 2'b11, 2'b01, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
